md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with HI/LO registers, located in the E stage
//   of the 5-stage MIPS pipeline beside the ALU.
//   It executes mult/multu/div/divu and mthi/mtlo, and returns HI/LO to the E-stage
//   result mux for mfhi/mflo.
//   It exports md_stall to the hazard unit, which stalls any md/mfhi/mflo instruction
//   held in D (PC_en=0, IR_D_en=0, IR_E_clr=1) while md_stall=1.
// PARAMETERS
//   MULT_LAT  5   cycles busy after a mult/multu start (>=1)
//   DIV_LAT   10  cycles busy after a div/divu start (>=1)
// PORTS
//   clk       in   1   single clock, rising edge
//   reset     in   1   synchronous, active-low; reset==0 at a rising edge clears state
//   start     in   1   E-stage instr is mult/multu/div/divu (decoded from IR_E)
//   md_op     in   3   MD_MULT/MULTU/DIV/DIVU/MTHI/MTLO/NONE (from IR_E)
//   rs_val    in   32  forwarded rs operand (after ForwardRSE mux)
//   rt_val    in   32  forwarded rt operand (after ForwardRTE mux)
//   busy      out  1   operation in flight
//   md_stall  out  1   start | busy (combinational), consumed by hazard unit
//   hi        out  32  HI register
//   lo        out  32  LO register
// BEHAVIOUR
//   Reset: busy=0, cnt=0, hi=0, lo=0, pending result=0; an in-flight op is discarded.
//   Start accept: start=1 & busy=0 & md_op in {MULT,MULTU,DIV,DIVU} at edge t:
//     - result is computed from rs_val/rt_val and latched internally;
//     - cnt := LAT (MULT_LAT or DIV_LAT).
//   Busy timing: busy = (cnt!=0), so busy is high for exactly LAT cycles after edge t.
//     - cnt decrements once per edge.
//     - On the edge where cnt goes 1->0, hi/lo take the pending result and busy falls.
//     - mfhi/mflo released by the stall therefore read the new values.
//   start=1 while busy=1: ignored (the hazard unit guarantees this cannot occur);
//     the current op continues unaffected.
//   mthi/mtlo: take effect at the next edge (hi:=rs_val or lo:=rs_val), no busy.
//     - Ignored while busy=1.
//     - Accepted only when start=0.
//   MULT: {hi,lo} = $signed(rs)*$signed(rt), 64-bit.
//   MULTU: {hi,lo} = rs*rt, 64-bit unsigned.
//   DIV: lo = quotient, hi = remainder, truncated toward zero; remainder sign = dividend.
//   DIVU: unsigned lo = rs/rt, hi = rs%rt.
//   Divide by zero: lo=32'hFFFFFFFF, hi=rs_val; full DIV_LAT busy time still applies.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//   hi/lo never change except at reset, the commit edge, or an mthi/mtlo edge.
//   md_op=NONE or start=0 with a non-MT op: no state change.
// STRUCTURE
//   Shared defines file holds: MD_* op encodings (3-bit), and mult/multu/div/divu/
//     mfhi/mflo/mthi/mtlo func codes; the hazard unit uses the same func codes.
//   No sub-module. Contents:
//     - one counter;
//     - pending 64-bit result register;
//     - HI/LO registers;
//     - behavioural * and / operators.
// TESTING
//   1. MULT rs=-3 (0xFFFFFFFD), rt=7 at edge t:
//      busy=1 for edges t+1..t+5; at t+5 hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   2. MULTU 0xFFFFFFFF*0xFFFFFFFF:
//      hi=0xFFFFFFFE, lo=0x00000001 after exactly 5 busy cycles.
//   3. DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy for 10 cycles.
//      Then DIVU 7/0: lo=0xFFFFFFFF, hi=7.
//   4. MTLO 0x1234 while busy (cycle 2 of a DIV): lo unchanged until commit.
//      MTLO 0x1234 when idle: lo=0x1234 next edge, busy stays 0.
//   5. start=1 at cycle 3 of a MULT: ignored; original result commits on schedule.
//      md_stall=1 throughout both cycles.
//   6. Reset driven low at cycle 4 of a DIV: next edge busy=0, hi=lo=0.
//      No later commit after reset is released.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: md_op encodings and the R-type func codes
// that the decoder and hazard unit use to recognise md/mfhi/mflo instructions.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1a;
  localparam logic [5:0] FUNC_DIVU  = 6'h1b;

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: computes the result at accept time, holds it
// pending for a fixed latency, then commits it to HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      pending;
  logic [63:0]      result;
  logic             is_mult, is_div;
  logic             neg_a, neg_b;
  logic [31:0]      div_a, div_b, quo, rem;

  assign busy     = (cnt != '0);
  assign md_stall = start | busy;

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
    is_div  = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    neg_a   = (md_op == MD_DIV) && rs_val[31];
    neg_b   = (md_op == MD_DIV) && rt_val[31];
    div_a   = neg_a ? ('0 - rs_val) : rs_val;
    div_b   = neg_b ? ('0 - rt_val) : rt_val;
    quo     = '0;
    rem     = '0;
    if (div_b != '0) begin
      quo = div_a / div_b;
      rem = div_a % div_b;
    end
    result = '0;
    case (md_op)
      MD_MULT:  result = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
      MD_MULTU: result = {32'h0, rs_val} * {32'h0, rt_val};
      MD_DIV, MD_DIVU: begin
        if (rt_val == '0)
          result = {rs_val, 32'hFFFF_FFFF};
        else
          result = {(neg_a ? ('0 - rem) : rem), ((neg_a ^ neg_b) ? ('0 - quo) : quo)};
      end
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        hi <= pending[63:32];
        lo <= pending[31:0];
      end
    end else if (start && (is_mult || is_div)) begin
      cnt     <= is_mult ? MULT_CNT : DIV_CNT;
      pending <= result;
    end else if (!start && (md_op == MD_MTHI)) begin
      hi <= rs_val;
    end else if (!start && (md_op == MD_MTLO)) begin
      lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios followed by random traffic,
// compared against a completion-time reference model.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference state: a pending result completes at absolute edge number m_due.
  int          n = 0;
  bit          m_pend_v;
  int          m_due;
  bit [63:0]   m_pend;
  bit [31:0]   m_hi, m_lo;

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic bit [63:0] ref_result(bit [2:0] op, bit [31:0] a, bit [31:0] b);
    longint x, y, q, r;
    bit [63:0] res;
    res = 64'h0;
    case (op)
      MD_MULT: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        res = x * y;
      end
      MD_MULTU: res = {32'h0, a} * {32'h0, b};
      MD_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          x = longint'($signed(a));
          y = longint'($signed(b));
          q = x / y;
          r = x % y;
          res = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  function automatic bit is_md(bit [2:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    n++;
    if (!reset) begin
      m_pend_v = 1'b0;
      m_hi = 0;
      m_lo = 0;
    end else if (m_pend_v) begin
      if (n == m_due) begin
        {m_hi, m_lo} = m_pend;
        m_pend_v = 1'b0;
      end
    end else if (start && is_md(md_op)) begin
      m_pend_v = 1'b1;
      m_due    = n + ((md_op == MD_MULT || md_op == MD_MULTU) ? MULT_LAT : DIV_LAT);
      m_pend   = ref_result(md_op, rs_val, rt_val);
    end else if (!start && md_op == MD_MTHI) begin
      m_hi = rs_val;
    end else if (!start && md_op == MD_MTLO) begin
      m_lo = rs_val;
    end
  endtask

  task automatic cycle(bit rst, bit st, bit [2:0] op, bit [31:0] a, bit [31:0] b);
    @(negedge clk);
    reset = rst; start = st; md_op = op; rs_val = a; rt_val = b;
    #1;
    chk("md_stall", {31'h0, md_stall}, {31'h0, st | m_pend_v});
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'h0, busy}, {31'h0, m_pend_v});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cycle(1'b1, 1'b0, MD_NONE, 32'h0, 32'h0);
  endtask

  function automatic bit [31:0] pick_val();
    int unsigned s;
    s = $urandom_range(0, 9);
    case (s)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0;
    m_pend_v = 0; m_due = 0; m_pend = 0; m_hi = 0; m_lo = 0;

    // Reset state (hi/lo/busy forced to zero).
    cycle(1'b0, 1'b0, MD_NONE, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, MD_NONE, 32'h0, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);

    // 1: MULT -3 * 7
    cycle(1'b1, 1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd7);
    idle(4);
    chk("t1_busy_last", {31'h0, busy}, 32'h1);
    idle(1);
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    chk("t1_lo", lo, 32'hFFFF_FFEB);

    // 2: MULTU max * max
    cycle(1'b1, 1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(5);
    chk("t2_hi", hi, 32'hFFFF_FFFE);
    chk("t2_lo", lo, 32'h0000_0001);

    // 3: DIV -7/2, then DIVU 7/0
    cycle(1'b1, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    chk("t3_lo", lo, 32'hFFFF_FFFD);
    chk("t3_hi", hi, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, MD_DIVU, 32'd7, 32'd0);
    idle(10);
    chk("t3z_lo", lo, 32'hFFFF_FFFF);
    chk("t3z_hi", hi, 32'd7);

    // DIV overflow corner
    cycle(1'b1, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // 4: MTLO while busy is dropped, MTLO when idle lands next edge
    cycle(1'b1, 1'b1, MD_DIV, 32'd100, 32'd7);
    idle(1);
    cycle(1'b1, 1'b0, MD_MTLO, 32'h1234, 32'h0);
    idle(8);
    chk("t4_lo_commit", lo, 32'd14);
    cycle(1'b1, 1'b0, MD_MTLO, 32'h1234, 32'h0);
    chk("t4_lo_idle", lo, 32'h1234);
    chk("t4_busy", {31'h0, busy}, 32'h0);

    // 5: second start during MULT is ignored
    cycle(1'b1, 1'b1, MD_MULT, 32'd6, 32'd9);
    idle(2);
    cycle(1'b1, 1'b1, MD_DIVU, 32'd50, 32'd3);
    idle(2);
    chk("t5_lo", lo, 32'd54);
    chk("t5_busy", {31'h0, busy}, 32'h0);

    // 6: reset during a DIV discards it
    cycle(1'b1, 1'b1, MD_DIV, 32'd1000, 32'd3);
    idle(3);
    cycle(1'b0, 1'b0, MD_NONE, 32'h0, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_lo", lo, 32'h0);
    idle(12);
    chk("t6_no_commit", lo, 32'h0);

    // Random traffic, including starts and MT ops while busy and rare resets
    for (int i = 0; i < 600; i++) begin
      bit [2:0] op;
      bit       st, rst;
      bit [31:0] a, b;
      op  = 3'($urandom_range(0, 6));
      st  = is_md(op) && (!m_pend_v || $urandom_range(0, 9) == 0);
      if (!is_md(op) && $urandom_range(0, 19) == 0) st = 1'b1;
      rst = ($urandom_range(0, 99) != 0);
      a   = pick_val();
      b   = ($urandom_range(0, 9) == 0) ? 32'h0 : pick_val();
      cycle(rst, st, op, a, b);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
